// File: rtl/csi_pkg.sv
// Shared definitions for the CSI frame writer: FSM states, default frame geometry
// and the width helpers used to split a RAM address into {bank, offset}.
package csi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_LINE  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DROP  = 3'd4
    } state_e;

    localparam int DEF_WORDS_PER_LINE  = 160;
    localparam int DEF_LINES_PER_FRAME = 480;
    localparam int DEF_ADDR_W          = 18;

    localparam int BANK_W     = 1;
    localparam int LINE_CNT_W = 10;

    // Column counter must reach WORDS_PER_LINE itself, not just WORDS_PER_LINE-1.
    function automatic int col_width(input int words);
        return $clog2(words + 1);
    endfunction

endpackage

// File: rtl/csi_frame_writer.sv
// csi_frame_writer: turns the CSI receiver payload stream into ping-pong frame-buffer RAM writes.
// Build option: define LINE_CHECK_EN to report bad line lengths on line_err.
module csi_frame_writer
    import csi_pkg::*;
#(
    parameter int WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int ADDR_W          = DEF_ADDR_W
) (
    input  logic                  mipi_clk_8,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  line_valid,
    input  logic [31:0]           data_i,
    input  logic [1:0]            rd_lock,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [31:0]           wr_data,
    output logic                  frame_done,
    output logic                  ready_bank,
    output logic                  frame_valid,
    output logic                  frame_dropped,
    output logic [LINE_CNT_W-1:0] line_cnt,
    output logic                  line_err
);

    localparam int OFF_W = ADDR_W - BANK_W;
    localparam int COL_W = col_width(WORDS_PER_LINE);

    localparam logic [COL_W-1:0]      COL_FULL  = COL_W'(WORDS_PER_LINE);
    localparam logic [OFF_W-1:0]      LINE_STEP = OFF_W'(WORDS_PER_LINE);
    localparam logic [LINE_CNT_W-1:0] LAST_LINE = LINE_CNT_W'(LINES_PER_FRAME - 1);

    state_e                  state_q;
    logic                    wr_bank_q;
    logic [OFF_W-1:0]        base_q;
    logic [COL_W-1:0]        col_q;
    logic [LINE_CNT_W-1:0]   line_cnt_q;
    logic                    ready_bank_q;
    logic                    frame_valid_q;
    logic                    frame_done_q;
    logic                    frame_dropped_q;

    logic                    wr_en_q;
    logic [ADDR_W-1:0]       wr_addr_q;
    logic [31:0]             wr_data_q;

    logic                    start_bank_d;
    logic                    col_room_d;
    logic                    last_line_d;
    logic [OFF_W-1:0]        wr_offset_d;
    logic                    wr_en_d;

    // A new frame always targets the bank the reader is not being offered.
    assign start_bank_d = frame_valid_q ? ~ready_bank_q : 1'b0;
    assign col_room_d   = (col_q < COL_FULL);
    assign last_line_d  = (line_cnt_q == LAST_LINE);
    assign wr_offset_d  = base_q + OFF_W'(col_q);
    assign wr_en_d      = line_valid && !frame_start &&
                          ((state_q == ST_ARMED) || ((state_q == ST_LINE) && col_room_d));

`ifdef LINE_CHECK_EN
    logic ovf_q;
    logic line_err_q;
    assign line_err = line_err_q;
`else
    assign line_err = 1'b0;
`endif

    always_ff @(posedge mipi_clk_8) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            wr_bank_q       <= 1'b0;
            base_q          <= '0;
            col_q           <= '0;
            line_cnt_q      <= '0;
            ready_bank_q    <= 1'b1;
            frame_valid_q   <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_dropped_q <= 1'b0;
`ifdef LINE_CHECK_EN
            ovf_q           <= 1'b0;
            line_err_q      <= 1'b0;
`endif
        end else begin
            frame_done_q    <= 1'b0;
            frame_dropped_q <= 1'b0;
`ifdef LINE_CHECK_EN
            line_err_q      <= 1'b0;
`endif
            if (frame_start) begin
                wr_bank_q  <= start_bank_d;
                base_q     <= '0;
                col_q      <= '0;
                line_cnt_q <= '0;
`ifdef LINE_CHECK_EN
                ovf_q      <= 1'b0;
`endif
                if (rd_lock[start_bank_d]) begin
                    state_q         <= ST_DROP;
                    frame_dropped_q <= 1'b1;
                end else begin
                    state_q <= ST_ARMED;
                end
            end else begin
                case (state_q)
                    ST_ARMED: begin
                        if (line_valid) begin
                            col_q   <= col_q + 1'b1;
                            state_q <= ST_LINE;
                        end
                    end
                    ST_LINE: begin
                        if (line_valid) begin
                            if (col_room_d) begin
                                col_q <= col_q + 1'b1;
                            end
`ifdef LINE_CHECK_EN
                            else begin
                                ovf_q <= 1'b1;
                            end
`endif
                        end else begin
                            base_q     <= base_q + LINE_STEP;
                            col_q      <= '0;
                            line_cnt_q <= line_cnt_q + 1'b1;
`ifdef LINE_CHECK_EN
                            ovf_q      <= 1'b0;
                            line_err_q <= (col_q != COL_FULL) || ovf_q;
`endif
                            if (last_line_d) begin
                                state_q       <= ST_DONE;
                                frame_done_q  <= 1'b1;
                                ready_bank_q  <= wr_bank_q;
                                frame_valid_q <= 1'b1;
                            end else begin
                                state_q <= ST_ARMED;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Registered RAM port: address and data only move when a word is actually written.
    always_ff @(posedge mipi_clk_8) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= wr_en_d;
            if (wr_en_d) begin
                wr_addr_q <= {wr_bank_q, wr_offset_d};
                wr_data_q <= data_i;
            end
        end
    end

    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign frame_done    = frame_done_q;
    assign ready_bank    = ready_bank_q;
    assign frame_valid   = frame_valid_q;
    assign frame_dropped = frame_dropped_q;
    assign line_cnt      = line_cnt_q;

endmodule
